// File: rtl/haeuslermarkus_fir_filter_pkg.sv
// Shared widths, mode encodings, reset coefficients and saturation helper for the FIR filter.
// Latency: none (declarations and a pure function only).
// Backpressure: none; nothing in here carries flow control.
package haeuslermarkus_fir_filter_pkg;

    localparam int TAPS      = 4;
    localparam int IDX_W     = 2;
    localparam int COEF_FRAC = 6;
    localparam int STEP      = 1;
    localparam int DATA_W    = 8;
    localparam int ACC_W     = 18;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_FILTER = 2'b10,
        MODE_ADAPT  = 2'b11
    } mode_t;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic [TAPS-1:0][DATA_W-1:0] vec_t;

    // c0 = 1.0 in Q1.6, all other taps zero: the filter comes out of reset as a passthrough
    localparam vec_t COEF_RESET = {8'h00, 8'h00, 8'h00, 8'h40};

    // Clamp a wide signed value into the signed 8-bit range
    function automatic data_t sat8(input logic signed [ACC_W-1:0] v);
        data_t r;
        if (v > 127)
            r = 8'sd127;
        else if (v < -128)
            r = -8'sd128;
        else
            r = v[DATA_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/haeuslermarkus_fir_filter_fir_mac.sv
// Sum of four 8x8 signed products, arithmetic shift by the coefficient fraction, saturate to 8 bits.
// Latency: purely combinational; the caller registers the result.
// Backpressure: none; output follows inputs continuously.
module haeuslermarkus_fir_filter_fir_mac
    import haeuslermarkus_fir_filter_pkg::*;
(
    input  vec_t  line,
    input  vec_t  coef,
    output data_t y
);

    logic signed [2*DATA_W-1:0] prod [TAPS];
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    shifted;

    // Accumulate in 18 bits so four full-scale products cannot overflow, then floor-shift and clamp
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            prod[k] = $signed(line[k]) * $signed(coef[k]);
            acc     = acc + ACC_W'(prod[k]);
        end
        shifted = acc >>> COEF_FRAC;
        y       = sat8(shifted);
    end

endmodule

// File: rtl/haeuslermarkus_fir_filter.sv
// 4-tap FIR with direct coefficient load and sign-sign LMS adaptation, TinyTapeout wrapper.
// Latency: 1 clk from FILTER sample on ui_in to result on uo_out.
// Backpressure: none; a mode on uio_in is acted upon at every enabled edge, ena=0 freezes all state.
module haeuslermarkus_fir_filter
    import haeuslermarkus_fir_filter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    mode_t              mode;
    logic [IDX_W-1:0]   tap_idx;
    vec_t               x_q;
    vec_t               c_q;
    data_t              y_q;
    vec_t               line_next;
    data_t              y_mac;
    vec_t               c_adapt;
    logic signed [8:0]  err;
    logic signed [ACC_W-1:0] c_sum;
    logic               unused_uio;

    assign mode       = mode_t'(uio_in[7:6]);
    assign tap_idx    = uio_in[IDX_W-1:0];
    assign unused_uio = ^uio_in[5:2];

    // Post-shift delay line: the new sample lands in x0 and x3 drops off
    assign line_next = {x_q[2], x_q[1], x_q[0], ui_in};

    haeuslermarkus_fir_filter_fir_mac u_mac (
        .line (line_next),
        .coef (c_q),
        .y    (y_mac)
    );

    // Sign-sign LMS: step each coefficient toward sign(e)*sign(xk), saturating instead of wrapping
    always_comb begin
        err     = {ui_in[7], ui_in} - {y_q[7], y_q};
        c_adapt = c_q;
        c_sum   = '0;
        for (int k = 0; k < TAPS; k++) begin
            c_sum = ACC_W'($signed(c_q[k]));
            if (err != 9'sd0 && x_q[k] != 8'h00) begin
                if (err[8] ^ x_q[k][7])
                    c_sum = c_sum - ACC_W'(STEP);
                else
                    c_sum = c_sum + ACC_W'(STEP);
            end
            c_adapt[k] = sat8(c_sum);
        end
    end

    // State registers: delay line, coefficients and output, all gated by ena
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            c_q <= COEF_RESET;
            y_q <= '0;
        end else if (ena) begin
            case (mode)
                MODE_HOLD: ;
                MODE_LOAD: c_q[tap_idx] <= ui_in;
                MODE_FILTER: begin
                    x_q <= line_next;
                    y_q <= y_mac;
                end
                MODE_ADAPT: c_q <= c_adapt;
                default: ;
            endcase
        end
    end

    assign uo_out  = y_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_haeuslermarkus_fir_filter.sv
module tb_haeuslermarkus_fir_filter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] M_HOLD   = 2'b00;
    localparam logic [1:0] M_LOAD   = 2'b01;
    localparam logic [1:0] M_FILTER = 2'b10;
    localparam logic [1:0] M_ADAPT  = 2'b11;

    haeuslermarkus_fir_filter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present one command just after a falling edge; it is applied at the next rising edge
    // and the task returns at the following falling edge, where outputs are stable.
    task automatic step(input logic [1:0] m, input logic [1:0] idx, input logic [7:0] d);
        ui_in  = d;
        uio_in = {m, 4'b0000, idx};
        @(negedge clk);
        uio_in = {M_HOLD, 6'b000000};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_oe", uio_oe, 8'h00);
        chk("rst_uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("pre_filter_uo", uo_out, 8'h00);

        // Passthrough from reset coefficients
        step(M_FILTER, 2'd0, 8'd50);
        chk("pass50", uo_out, 8'h32);
        chk("oe_run", uio_oe, 8'h00);
        chk("uio_out_run", uio_out, 8'h00);

        // Loaded coefficients: 0.5 on c0 and c1
        do_reset();
        step(M_LOAD, 2'd0, 8'd32);
        step(M_LOAD, 2'd1, 8'd32);
        chk("load_keeps_uo", uo_out, 8'h00);
        step(M_FILTER, 2'd0, 8'd100);
        chk("half_100", uo_out, 8'd50);
        step(M_FILTER, 2'd0, 8'd100);
        chk("two_halves_100", uo_out, 8'd100);

        // Floor shift: -1*32 = -32, >>>6 = -1 (not 0)
        do_reset();
        step(M_LOAD, 2'd0, 8'd32);
        step(M_FILTER, 2'd0, 8'hFF);
        chk("floor_neg", uo_out, 8'hFF);

        // Output saturation both ways
        do_reset();
        step(M_LOAD, 2'd0, 8'd127);
        step(M_FILTER, 2'd0, 8'd127);
        chk("sat_pos", uo_out, 8'h7F);
        step(M_FILTER, 2'd0, 8'h80);
        chk("sat_neg", uo_out, 8'h80);

        // Coefficient saturation: c0=127 pushed upward stays 127
        do_reset();
        step(M_LOAD, 2'd0, 8'd127);
        step(M_FILTER, 2'd0, 8'd1);
        chk("c127_x1", uo_out, 8'd1);
        step(M_ADAPT, 2'd0, 8'd100);
        chk("adapt_keeps_uo", uo_out, 8'd1);
        step(M_FILTER, 2'd0, 8'd64);
        chk("coef_sat", uo_out, 8'd127);

        // LMS adaptation
        do_reset();
        step(M_FILTER, 2'd0, 8'd10);
        chk("adapt_pre", uo_out, 8'd10);
        step(M_ADAPT, 2'd0, 8'd20);
        chk("adapt_uo_hold", uo_out, 8'd10);
        step(M_FILTER, 2'd0, 8'd64);
        chk("c0_65", uo_out, 8'd65);
        step(M_ADAPT, 2'd0, 8'd65);
        step(M_FILTER, 2'd0, 8'd64);
        chk("e_zero_nochange", uo_out, 8'd65);
        // e = -65: c0 65->64, c1 0->-1 (x1=64), c2 0->-1 (x2=10), c3 unchanged (x3=0)
        step(M_ADAPT, 2'd0, 8'd0);
        step(M_FILTER, 2'd0, 8'd0);
        chk("e_neg", uo_out, 8'hFE);

        // ena low freezes everything
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(M_FILTER, 2'd0, 8'd99);
            chk("ena_hold", uo_out, 8'hFE);
        end
        ena = 1'b1;
        // line [99,0,64,64], coef [64,-1,-1,0]: 6336-64 = 6272 >>6 = 98
        step(M_FILTER, 2'd0, 8'd99);
        chk("ena_resume", uo_out, 8'd98);

        // Asynchronous reset between edges
        step(M_LOAD, 2'd0, 8'd10);
        chk("load_before_rst", uo_out, 8'd98);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(M_FILTER, 2'd0, 8'd7);
        chk("post_rst_c0", uo_out, 8'd7);
        step(M_FILTER, 2'd0, 8'd7);
        chk("post_rst_c1", uo_out, 8'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case something stalls the sequence
    initial begin
        #100000;
        $display("FAIL timeout: observed=stuck expected=finish");
        $fatal(1, "timeout");
    end

endmodule
